inventory_txn_seq: RTL and testbench
====================================

// Module: inventory_txn_seq
// PURPOSE
//  Sequential transaction controller for the canteen inventory/billing datapath.
//  It holds the live stock count, unit price and running cash total in registers.
//  It accepts one sale or restock request at a time over a valid/ready handshake.
//  For each request it checks feasibility, computes qty*price with a shift-add
//  multiplier, commits the new stock and total, and returns a response record.
// PARAMETERS
//  QTY_W       4   width of quantity and stock count
//  PRICE_W     4   width of unit price
//  TOTAL_W     8   width of amount and cash total (must be >= QTY_W+PRICE_W)
//  INIT_STOCK  0   stock count loaded at reset
//  INIT_TOTAL  0   cash total loaded at reset
// PORTS
//  clk         in   1        single clock, rising edge
//  reset_n     in   1        asynchronous, active-low reset
//  price_load  in   1        load price_in into the price register (any state)
//  price_in    in   PRICE_W  new unit price
//  req_valid   in   1        request present
//  req_ready   out  1        high only in IDLE
//  req_sale    in   1        1 = sale (stock -= qty, total += amt); 0 = restock (stock += qty, total -= amt)
//  req_qty     in   QTY_W    items requested
//  rsp_valid   out  1        response present; held until rsp_ready
//  rsp_ready   in   1        consumer accepts response
//  rsp_ok      out  1        1 = committed
//  rsp_err     out  2        00 none, 01 insufficient stock, 10 stock overflow
//  rsp_amount  out  TOTAL_W  qty*price of this transaction (0 on error)
//  stock_ct    out  QTY_W    registered stock count
//  total       out  TOTAL_W  registered cash total
//  empty       out  1        stock_ct == 0 (combinational from the register)
//  busy        out  1        state != IDLE
// BEHAVIOUR
//  Reset values: stock_ct=INIT_STOCK, total=INIT_TOTAL, price=0, state=IDLE,
//    rsp_valid=0, rsp_ok=0, rsp_err=00, rsp_amount=0; so req_ready=1 and busy=0.
//  Reset asserted mid-operation aborts the transaction: no response, no commit.
//  FSM: IDLE -> CHECK -> MUL(QTY_W cycles) -> COMMIT -> RESP -> IDLE.
//    Error path: CHECK -> RESP.
//  IDLE: on req_valid&req_ready, latch req_sale, req_qty and a snapshot of price.
//    price_load in later states changes only the price register, never the snapshot.
//  CHECK: sale with qty>stock_ct -> err 01.
//    Restock with stock_ct+qty > 2^QTY_W-1 -> err 10.
//  MUL: one multiplier bit per cycle, LSB first; amount is exact (no truncation).
//  COMMIT: stock_ct and total update on this edge. Total arithmetic is modulo 2^TOTAL_W
//    (sale adds, restock subtracts). Wrap is allowed and not flagged.
//  RESP: rsp_valid=1, and rsp_* stay stable until rsp_valid&rsp_ready. Return to IDLE on the next edge.
//  Latency from the accept edge T: rsp_valid high at T+QTY_W+3 on success, T+2 on error.
//    Defaults: T+7 and T+2.
//  qty=0 is legal: ok=1, amount=0, state unchanged apart from the pass through the FSM.
//  Error responses leave stock_ct and total untouched.
//  price_load together with a request accept in the same cycle: the snapshot takes the OLD price.
// STRUCTURE
//  Package inv_pkg holds: state encoding (IDLE, CHECK, MUL, COMMIT, RESP), rsp_err codes,
//    and default width constants.
//  Sub-module shift_add_mult (start/done, QTY_W x PRICE_W -> TOTAL_W) is instantiated once.
//  FSM, feasibility check and commit logic live in the top.
// TESTING
//  1 Reset: pulse reset_n low mid-idle.
//    -> stock_ct=0, total=0, empty=1, req_ready=1, rsp_valid=0.
//  2 Restock: price=3, restock qty=10.
//    -> rsp at T+7: ok=1, amount=30, stock_ct=10, total=226 (wrap).
//  3 Sale: price=7, sale qty=4 (stock 10), price_load 15 at T+3.
//    -> amount=28, stock_ct=6, total=254.
//  4 Reject: stock 6, sale qty=7 -> rsp at T+2, err=01, amount=0, stock/total unchanged.
//    Restock qty=10 -> err=10, stock/total unchanged.
//  5 Backpressure: rsp_ready=0 for 10 cycles.
//    -> rsp_* stable, req_ready=0, a second request is not accepted until rsp handshake.
//  6 Abort: reset_n low during MUL.
//    -> no rsp_valid, stock/total at INIT, next request completes normally.

Source files
------------

// File: rtl/inventory_txn_seq_pkg.sv
// Shared definitions for the canteen inventory/billing transaction controller.
// Holds the FSM state encoding, response error codes and default widths used
// by the interface, the shift-add multiplier and the top-level controller.
package inventory_txn_seq_pkg;

  localparam int DEF_QTY_W   = 4;
  localparam int DEF_PRICE_W = 4;
  localparam int DEF_TOTAL_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_MUL    = 3'd2,
    ST_COMMIT = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_STOCK = 2'b01,
    ERR_OVF   = 2'b10
  } rsp_err_t;

endpackage

// File: rtl/inventory_txn_seq_if.sv
// Request/response handshake bundle for the inventory transaction controller.
//   req_valid/req_ready : request handshake (one transaction in flight)
//   req_sale            : 1 = sale, 0 = restock
//   req_qty             : item count of the request
//   rsp_valid/rsp_ready : response handshake, response held until accepted
//   rsp_ok/rsp_err      : commit flag and error code
//   rsp_amount          : qty*price of the transaction (0 on error)
// master = requester/consumer side, slave = the controller.
import inventory_txn_seq_pkg::*;

interface inventory_txn_seq_if #(
  parameter int QTY_W   = DEF_QTY_W,
  parameter int TOTAL_W = DEF_TOTAL_W
);

  logic               req_valid;
  logic               req_ready;
  logic               req_sale;
  logic [QTY_W-1:0]   req_qty;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_ok;
  logic [1:0]         rsp_err;
  logic [TOTAL_W-1:0] rsp_amount;

  modport master (
    output req_valid, req_sale, req_qty, rsp_ready,
    input  req_ready, rsp_valid, rsp_ok, rsp_err, rsp_amount
  );

  modport slave (
    input  req_valid, req_sale, req_qty, rsp_ready,
    output req_ready, rsp_valid, rsp_ok, rsp_err, rsp_amount
  );

endinterface

// File: rtl/inventory_txn_seq_shift_add_mult.sv
// Sequential shift-add multiplier: QTY_W x PRICE_W -> TOTAL_W, exact.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   start        : load operands and begin (one-cycle pulse)
//   mplier_in    : multiplier (quantity), consumed one bit per cycle, LSB first
//   mcand_in     : multiplicand (unit price)
//   done         : high during the final accumulation cycle, so a controller
//                  that advances on done sees the finished product next cycle
//   product      : accumulated result, held until the next start
import inventory_txn_seq_pkg::*;

module inventory_txn_seq_shift_add_mult #(
  parameter int QTY_W   = DEF_QTY_W,
  parameter int PRICE_W = DEF_PRICE_W,
  parameter int TOTAL_W = DEF_TOTAL_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [QTY_W-1:0]   mplier_in,
  input  logic [PRICE_W-1:0] mcand_in,
  output logic               done,
  output logic [TOTAL_W-1:0] product
);

  localparam int CNT_W = $clog2(QTY_W + 1);

  logic [TOTAL_W-1:0] mcand;
  logic [QTY_W-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  // The multiplicand is widened to TOTAL_W so its shifted copies never lose
  // bits; TOTAL_W >= QTY_W+PRICE_W keeps the product exact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else if (start) begin
      product <= '0;
      mcand   <= TOTAL_W'(mcand_in);
      mplier  <= mplier_in;
      cnt     <= CNT_W'(QTY_W);
    end else if (cnt != '0) begin
      if (mplier[0]) begin
        product <= product + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end
  end

  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/inventory_txn_seq.sv
// Sequential transaction controller for the canteen inventory/billing path.
// Holds stock count, unit price and running cash total; serves one sale or
// restock at a time: feasibility check, shift-add qty*price, commit, response.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset (aborts any txn)
//   price_load   : load price_in into the price register (any state)
//   price_in     : new unit price
//   bus          : request/response handshake bundle (slave side)
//   stock_ct     : registered stock count
//   total        : registered cash total (modulo 2^TOTAL_W)
//   empty        : stock_ct == 0
//   busy         : controller not in IDLE
import inventory_txn_seq_pkg::*;

module inventory_txn_seq #(
  parameter int QTY_W      = DEF_QTY_W,
  parameter int PRICE_W    = DEF_PRICE_W,
  parameter int TOTAL_W    = DEF_TOTAL_W,
  parameter int INIT_STOCK = 0,
  parameter int INIT_TOTAL = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 price_load,
  input  logic [PRICE_W-1:0]   price_in,
  inventory_txn_seq_if.slave   bus,
  output logic [QTY_W-1:0]     stock_ct,
  output logic [TOTAL_W-1:0]   total,
  output logic                 empty,
  output logic                 busy
);

  state_t             state;
  logic [PRICE_W-1:0] price;
  logic [PRICE_W-1:0] snap_price;
  logic               snap_sale;
  logic [QTY_W-1:0]   snap_qty;
  rsp_err_t           pend_err;
  rsp_err_t           check_err;
  logic [QTY_W:0]     restock_sum;
  logic               mul_start;
  logic               mul_done;
  logic [TOTAL_W-1:0] product;

  // Price register is independent of the FSM; the transaction works from its
  // own snapshot, so a load during a transaction only affects later requests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      price <= '0;
    end else if (price_load) begin
      price <= price_in;
    end
  end

  // Feasibility of the latched request against the live stock. The extra
  // carry bit of restock_sum flags a stock count that would not fit.
  always_comb begin
    restock_sum = {1'b0, stock_ct} + {1'b0, snap_qty};
    check_err   = ERR_NONE;
    if (snap_sale) begin
      if (snap_qty > stock_ct) begin
        check_err = ERR_STOCK;
      end
    end else if (restock_sum[QTY_W]) begin
      check_err = ERR_OVF;
    end
  end

  assign mul_start = (state == ST_CHECK) && (check_err == ERR_NONE);

  inventory_txn_seq_shift_add_mult #(
    .QTY_W   (QTY_W),
    .PRICE_W (PRICE_W),
    .TOTAL_W (TOTAL_W)
  ) u_mult (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (mul_start),
    .mplier_in (snap_qty),
    .mcand_in  (snap_price),
    .done      (mul_done),
    .product   (product)
  );

  // Main FSM with registered response outputs. In RESP the first edge raises
  // rsp_valid and loads the response fields; they then hold until the
  // consumer takes them, and that same edge returns to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      stock_ct       <= QTY_W'(INIT_STOCK);
      total          <= TOTAL_W'(INIT_TOTAL);
      snap_price     <= '0;
      snap_sale      <= 1'b0;
      snap_qty       <= '0;
      pend_err       <= ERR_NONE;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_ok     <= 1'b0;
      bus.rsp_err    <= ERR_NONE;
      bus.rsp_amount <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            snap_sale  <= bus.req_sale;
            snap_qty   <= bus.req_qty;
            snap_price <= price;
            state      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          pend_err <= check_err;
          state    <= (check_err == ERR_NONE) ? ST_MUL : ST_RESP;
        end
        ST_MUL: begin
          if (mul_done) begin
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          if (snap_sale) begin
            stock_ct <= stock_ct - snap_qty;
            total    <= total + product;
          end else begin
            stock_ct <= stock_ct + snap_qty;
            total    <= total - product;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (!bus.rsp_valid) begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_ok     <= (pend_err == ERR_NONE);
            bus.rsp_err    <= pend_err;
            bus.rsp_amount <= (pend_err == ERR_NONE) ? product : '0;
          end else if (bus.rsp_ready) begin
            bus.rsp_valid  <= 1'b0;
            bus.rsp_ok     <= 1'b0;
            bus.rsp_err    <= ERR_NONE;
            bus.rsp_amount <= '0;
            state          <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign empty         = (stock_ct == '0);

endmodule

// File: tb/tb_inventory_txn_seq.sv
// Self-checking bench for inventory_txn_seq. Directed scenarios followed by
// randomized sale/restock traffic, all checked against a behavioural model of
// stock, price and cash total kept as plain integers.
module tb_inventory_txn_seq;

  localparam int QTY_W   = 4;
  localparam int PRICE_W = 4;
  localparam int TOTAL_W = 8;
  localparam int MAX_Q   = (1 << QTY_W) - 1;
  localparam int MOD_T   = 1 << TOTAL_W;

  logic               clk;
  logic               reset_n;
  logic               price_load;
  logic [PRICE_W-1:0] price_in;
  logic [QTY_W-1:0]   stock_ct;
  logic [TOTAL_W-1:0] total;
  logic               empty;
  logic               busy;

  inventory_txn_seq_if #(.QTY_W(QTY_W), .TOTAL_W(TOTAL_W)) bus ();

  inventory_txn_seq #(
    .QTY_W      (QTY_W),
    .PRICE_W    (PRICE_W),
    .TOTAL_W    (TOTAL_W),
    .INIT_STOCK (0),
    .INIT_TOTAL (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .price_load (price_load),
    .price_in   (price_in),
    .bus        (bus),
    .stock_ct   (stock_ct),
    .total      (total),
    .empty      (empty),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_stock = 0;
  int m_total = 0;
  int m_price = 0;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_price(input int v);
    price_load = 1'b1;
    price_in   = PRICE_W'(v);
    tick();
    price_load = 1'b0;
    m_price    = v;
  endtask

  task automatic model_reset();
    m_stock = 0;
    m_total = 0;
    m_price = 0;
  endtask

  // Drives one request and checks its response against the model.
  // load_at >= 0 pulses price_load with load_val that many cycles after the
  // accept edge; hold > 0 withholds rsp_ready for that many cycles while a
  // second request is presented.
  task automatic applyStimulus(input logic sale, input int qty, input int load_at,
                               input int load_val, input int hold);
    int       lat;
    int       guard;
    int       snap_p;
    int       exp_amt;
    int       exp_err;
    int       exp_lat;
    logic     exp_ok;
    logic [TOTAL_W-1:0] held_amt;
    logic [1:0]         held_err;
    logic               held_ok;

    snap_p  = m_price;
    exp_err = 0;
    if (sale && qty > m_stock) exp_err = 1;
    else if (!sale && m_stock + qty > MAX_Q) exp_err = 2;
    exp_ok  = (exp_err == 0);
    exp_amt = exp_ok ? qty * snap_p : 0;
    exp_lat = exp_ok ? QTY_W + 3 : 2;

    bus.rsp_ready = (hold == 0);
    bus.req_valid = 1'b1;
    bus.req_sale  = sale;
    bus.req_qty   = QTY_W'(qty);
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      tick();
      guard++;
    end
    checkOutput("req_ready_before_accept", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = 1'b0;

    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      if (lat == load_at) begin
        price_load = 1'b1;
        price_in   = PRICE_W'(load_val);
      end else begin
        price_load = 1'b0;
      end
      tick();
      lat++;
    end
    price_load = 1'b0;
    if (load_at >= 0 && load_at < lat) m_price = load_val;

    if (exp_ok) begin
      if (sale) begin
        m_stock = m_stock - qty;
        m_total = (m_total + exp_amt) % MOD_T;
      end else begin
        m_stock = m_stock + qty;
        m_total = (m_total - exp_amt + MOD_T) % MOD_T;
      end
    end

    checkOutput("rsp_latency", 32'(lat), 32'(exp_lat));
    checkOutput("rsp_valid", 32'(bus.rsp_valid), 1);
    checkOutput("rsp_ok", 32'(bus.rsp_ok), 32'(exp_ok));
    checkOutput("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    checkOutput("rsp_amount", 32'(bus.rsp_amount), 32'(exp_amt));
    checkOutput("stock_ct", 32'(stock_ct), 32'(m_stock));
    checkOutput("total", 32'(total), 32'(m_total));
    checkOutput("empty", 32'(empty), 32'(m_stock == 0));
    checkOutput("busy_in_resp", 32'(busy), 1);

    if (hold > 0) begin
      held_amt = bus.rsp_amount;
      held_err = bus.rsp_err;
      held_ok  = bus.rsp_ok;
      bus.req_valid = 1'b1;
      bus.req_sale  = 1'b1;
      bus.req_qty   = QTY_W'(1);
      for (int i = 0; i < hold; i++) begin
        tick();
        checkOutput("bp_rsp_valid", 32'(bus.rsp_valid), 1);
        checkOutput("bp_rsp_stable", {21'b0, held_ok, held_err, held_amt},
                    {21'b0, bus.rsp_ok, bus.rsp_err, bus.rsp_amount});
        checkOutput("bp_req_ready", 32'(bus.req_ready), 0);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
    end

    tick();
    checkOutput("rsp_valid_after_hs", 32'(bus.rsp_valid), 0);
    checkOutput("req_ready_after_hs", 32'(bus.req_ready), 1);
    checkOutput("stock_after_hs", 32'(stock_ct), 32'(m_stock));
  endtask

  initial begin
    int saw_valid;
    logic rs;
    int   rq;

    reset_n       = 1'b0;
    price_load    = 1'b0;
    price_in      = '0;
    bus.req_valid = 1'b0;
    bus.req_sale  = 1'b0;
    bus.req_qty   = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset pulse in the middle of an idle period, between clock edges.
    set_price(9);
    tick();
    reset_n = 1'b0;
    #2;
    model_reset();
    checkOutput("reset_stock", 32'(stock_ct), 0);
    checkOutput("reset_total", 32'(total), 0);
    checkOutput("reset_empty", 32'(empty), 1);
    checkOutput("reset_req_ready", 32'(bus.req_ready), 1);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    #1;
    reset_n = 1'b1;
    tick();

    // Restock 10 at price 3: total wraps to 226.
    set_price(3);
    applyStimulus(1'b0, 10, -1, 0, 0);
    checkOutput("restock_total_226", 32'(total), 226);

    // Sale 4 at price 7 with a price change mid-transaction.
    set_price(7);
    applyStimulus(1'b1, 4, 3, 15, 0);
    checkOutput("sale_total_254", 32'(total), 254);
    checkOutput("sale_stock_6", 32'(stock_ct), 6);

    // Rejected sale and rejected restock.
    applyStimulus(1'b1, 7, -1, 0, 0);
    applyStimulus(1'b0, 10, -1, 0, 0);
    checkOutput("reject_stock_6", 32'(stock_ct), 6);
    checkOutput("reject_total_254", 32'(total), 254);

    // Backpressure for 10 cycles, then a normal follow-up request.
    applyStimulus(1'b1, 2, -1, 0, 10);
    applyStimulus(1'b0, 0, -1, 0, 0);

    // Abort during MUL.
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_sale  = 1'b0;
    bus.req_qty   = QTY_W'(5);
    tick();
    bus.req_valid = 1'b0;
    repeat (3) tick();
    checkOutput("abort_busy_before", 32'(busy), 1);
    reset_n = 1'b0;
    #2;
    model_reset();
    reset_n = 1'b1;
    saw_valid = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.rsp_valid) saw_valid = 1;
    end
    checkOutput("abort_no_rsp", 32'(saw_valid), 0);
    checkOutput("abort_stock_init", 32'(stock_ct), 0);
    checkOutput("abort_total_init", 32'(total), 0);
    checkOutput("abort_idle", 32'(busy), 0);
    set_price(6);
    applyStimulus(1'b0, 5, -1, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) set_price(int'($urandom_range(0, 15)));
      rs = 1'($urandom_range(0, 1));
      rq = int'($urandom_range(0, MAX_Q));
      if ($urandom_range(0, 2) == 0)
        applyStimulus(rs, rq, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 0);
      else
        applyStimulus(rs, rq, -1, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
